// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: shares one registered output channel among eight requesters.
//
// A round-robin arbiter picks one pending requester and drives the select of
// an internal 8:1 word mux. The selected word is registered and offered
// downstream with a valid/ready handshake. The winner receives a one-cycle
// combinational ack when its word transfers. There is always one idle cycle
// between transfers, so an acked requester can drop req before the next pick.
//
// Optional feature: define MUX8_ARB_LOCK_EN to enable burst lock. In that
// build, lock_i[out_sel_o] is sampled in the transfer cycle. If it is set, the
// following idle cycle re-grants the same requester while its req is still
// high. Without the macro, lock_i is ignored.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   req_i        per-requester pending flag, held until its ack
//   in_data_i    requester i word at [i*WIDTH +: WIDTH]
//   lock_i       per-requester burst hold (MUX8_ARB_LOCK_EN only)
//   out_valid_o  out_data_o holds a granted word
//   out_ready_i  sink accepts out_data_o this cycle
//   out_data_o   registered mux output
//   out_sel_o    index of current/last grant
//   ack_o        one-hot transfer acknowledge, combinational
//   busy_o       high while a granted word is waiting for the sink
module mux8_rr_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [7:0]         req_i,
  input  logic [8*WIDTH-1:0] in_data_i,
  input  logic [7:0]         lock_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [2:0]         out_sel_o,
  output logic [7:0]         ack_o,
  output logic               busy_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [2:0]       rr_idx;
  logic [2:0]       rr_cand;
  logic             rr_found;
  logic [2:0]       win_idx;
  logic             lock_hit;
  logic [WIDTH-1:0] mux_word;

  // Rotating search: start just after the last winner and wrap round to it.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    rr_cand  = ptr_q;
    for (int k = 1; k <= 8; k++) begin
      rr_cand = ptr_q + 3'(k);
      if (!rr_found && req_i[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

`ifdef MUX8_ARB_LOCK_EN
  logic lock_q, lock_d;

  // A locked re-grant applies only while the holder still requests.
  assign lock_hit = lock_q & req_i[sel_q];

  always_comb begin
    lock_d = lock_q;
    if (state_q == StBusy) begin
      if (out_ready_i) begin
        lock_d = lock_i[sel_q];
      end
    end else begin
      // Lock is honoured only in the idle cycle that follows the transfer.
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign lock_hit    = 1'b0;
`endif

  assign win_idx = lock_hit ? sel_q : rr_idx;

  // 8:1 word mux driven by the arbiter select.
  always_comb begin
    mux_word = in_data_i[win_idx*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d = StBusy;
          sel_d   = win_idx;
          data_d  = mux_word;
          if (!lock_hit) begin
            ptr_d = win_idx;
          end
        end
      end
      StBusy: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= 3'd7;
      sel_q   <= 3'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = (state_q == StBusy);
  assign busy_o      = (state_q == StBusy);
  assign out_data_o  = data_q;
  assign out_sel_o   = sel_q;

  // A word discarded by reset is never acknowledged.
  always_comb begin
    ack_o = 8'h00;
    if (out_valid_o && out_ready_i && rst_ni) begin
      ack_o = 8'h01 << sel_q;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst_n;
  logic [7:0]   req;
  logic [8*W-1:0] in_data;
  logic [7:0]   lock;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_sel;
  logic [7:0]   ack;
  logic         busy;

  logic [W-1:0] word [8];

  always_comb begin
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = word[i];
  end

  mux8_rr_arbiter #(.WIDTH(W)) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .in_data_i  (in_data),
    .lock_i     (lock),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_sel_o  (out_sel),
    .ack_o      (ack),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of the arbiter.
  bit           m_busy;
  int           m_sel;
  int           m_ptr;
  logic [W-1:0] m_data;
  bit           m_lock;
  logic [7:0]   last_ack;
  int           grants[$];

  function automatic int rr_pick(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    logic [7:0] exp_ack;
    int w;
    #1;
    exp_ack = (m_busy && out_ready && rst_n) ? 8'(1 << m_sel) : 8'h00;
    check("out_valid", 64'(out_valid), 64'(m_busy));
    check("busy", 64'(busy), 64'(m_busy));
    check("out_sel", 64'(out_sel), 64'(m_sel));
    check("out_data", out_data, m_data);
    check("ack", 64'(ack), 64'(exp_ack));
    last_ack = exp_ack;
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_data = '0; m_ptr = 7; m_lock = 0;
    end else if (m_busy) begin
      if (out_ready) begin
        m_busy = 0;
`ifdef MUX8_ARB_LOCK_EN
        m_lock = lock[m_sel];
`endif
      end
    end else begin
      if (req != 8'h00) begin
        if (m_lock && req[m_sel]) begin
          w = m_sel;
        end else begin
          w = rr_pick(req, m_ptr);
          m_ptr = w;
        end
        m_busy = 1; m_sel = w; m_data = word[w];
        grants.push_back(w);
      end
      m_lock = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
    grants.delete();
    last_ack = 8'h00;
  endtask

  task automatic check_grants(input string tag, input int exp_q[$]);
    check({tag, "_count"}, 64'(grants.size() >= exp_q.size()), 64'(1));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < grants.size()) check(tag, 64'(grants[i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    int acks0;
    rst_n = 1'b0; req = 8'hFF; lock = 8'h00; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) word[i] = 64'(i + 1);
    m_busy = 0; m_sel = 0; m_data = '0; m_ptr = 7; m_lock = 0; last_ack = 8'h00;
    @(posedge clk);
    @(negedge clk);

    // Reset with all requesting, then a full rotation at full throughput.
    do_reset(3);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", out_data, 64'(0));
    repeat (18) step();
    check("rst_ngrants", 64'(grants.size()), 64'(9));
    check_grants("rst_order", '{0, 1, 2, 3, 4, 5, 6, 7, 0});

    // Two constant requesters alternate purely by rotation.
    do_reset(1);
    req = 8'b1000_0100;
    repeat (8) step();
    check_grants("rotation", '{2, 7, 2, 7});

    // Long stall on requester 3 while requester 5 arrives.
    do_reset(1);
    req = 8'h08; word[3] = 64'hDEAD_BEEF; out_ready = 1'b0;
    step();
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin req[5] = 1'b1; word[5] = {$urandom, $urandom}; end
      step();
      check("stall_sel", 64'(out_sel), 64'(3));
      check("stall_data", out_data, 64'hDEAD_BEEF);
      check("stall_ack", 64'(ack), 64'(0));
    end
    out_ready = 1'b1;
    #1 check("stall_release_ack", 64'(ack), 64'h08);
    step();
    req[3] = 1'b0;
    step();
    check("stall_next_sel", 64'(out_sel), 64'(5));
    check("stall_next_valid", 64'(out_valid), 64'(1));
    req = 8'h00;
    step();

    // Reset while busy: no ack, pointer back to 7.
    do_reset(1);
    req = 8'h01; out_ready = 1'b0;
    step();
    step();
    out_ready = 1'b1; rst_n = 1'b0;
    #1 check("midrst_ack", 64'(ack), 64'(0));
    step();
    rst_n = 1'b1; req = 8'h03;
    check("midrst_valid", 64'(out_valid), 64'(0));
    step();
    check("midrst_winner", 64'(out_sel), 64'(0));
    req = 8'h00;
    step();

    // Burst lock on requester 0 for the first transfers.
    do_reset(1);
    req = 8'h11; out_ready = 1'b1; acks0 = 0;
    for (int c = 0; c < 10; c++) begin
      lock[0] = (acks0 < 2);
      step();
      if (last_ack[0]) acks0++;
    end
    lock = 8'h00;
`ifdef MUX8_ARB_LOCK_EN
    check_grants("lock", '{0, 0, 0, 4});
`else
    check_grants("lock", '{0, 4, 0, 4});
`endif

    // Randomized traffic with protocol-respecting requesters.
    req = 8'h00;
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (last_ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && ($urandom % 4 == 0)) begin
          req[i] = 1'b1;
          word[i] = {$urandom, $urandom};
        end else if (req[i] && !(m_busy && m_sel == i) && ($urandom % 16 == 0)) begin
          req[i] = 1'b0;
        end
      end
      rst_n = ($urandom % 200) != 0;
      out_ready = ($urandom % 3) != 0;
      lock = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
